picorv32_mem_responder: RTL and testbench

Memory-side responder for the picorv32 native memory interface: the target that answers mem_valid/mem_addr/mem_wstrb requests with mem_ready/mem_rdata.
Backed by an internal word-addressed RAM with a fixed, parameterised wait-state latency.
Sticky flags report out-of-range accesses and initiator protocol violations.
Used as the memory model in core-level formal and simulation benches, in place of an unconstrained mem_ready/mem_rdata.

---
 rtl/picorv32_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_picorv32_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_responder.sv
// -----------------------------------------------------------------------------
// picorv32_mem_responder
//
// Memory-side target for the picorv32 native memory interface. It accepts a
// mem_valid request and latches it. After a fixed number of wait states it
// answers with a single-cycle mem_ready strobe and the read data. A
// word-addressed internal RAM backs the responder. Two sticky flags record
// accesses outside the RAM window and initiator protocol violations.
//
// Request timing: mem_valid first seen in cycle t gives mem_ready in cycle
// t+1+WAIT_CYCLES. Back-to-back requests complete once every
// WAIT_CYCLES+2 cycles.
//
// Parameters:
//   MEM_WORDS    RAM depth in 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (word aligned)
//   WAIT_CYCLES  wait states between acceptance and mem_ready (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset; dominates all inputs
//   mem_valid  in   request valid
//   mem_instr  in   request is an instruction fetch (stability check only)
//   mem_addr   in   byte address
//   mem_wdata  in   write data
//   mem_wstrb  in   byte write enables, 0 = read
//   mem_ready  out  one-cycle response strobe
//   mem_rdata  out  read data, valid while mem_ready is high
//   err_oob    out  sticky: out-of-range or misaligned access
//   err_proto  out  sticky: request changed or dropped before mem_ready
//   txn_count  out  completed transactions, wraps at 2^32
// -----------------------------------------------------------------------------
module picorv32_mem_responder #(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        err_oob,
   output logic        err_proto,
   output logic [31:0] txn_count
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
   localparam logic [31:0] DEPTH     = 32'(MEM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        load_rdata;

   // Request fields captured at acceptance. All later decode and write work
   // uses these fields, not the live bus.
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wstrb;
   logic        lat_instr;
   logic [3:0]  wait_cnt;

   logic [31:0] ram [MEM_WORDS];

   // --------------------------------------------------------------------------
   // Address decode
   // --------------------------------------------------------------------------
   // With zero wait states the edge that accepts a request is also the edge
   // that loads mem_rdata. The latch is not written yet at that point, so
   // IDLE decodes the live address. Every other state decodes the latched
   // copy.
   logic [31:0]   dec_addr;
   logic [29:0]   dec_word_off;
   logic          dec_in_range;
   logic [AW-1:0] dec_idx;

   always_comb begin
      dec_addr     = (state == S_IDLE) ? mem_addr : lat_addr;
      // BASE_ADDR is word aligned, so subtracting word addresses gives the
      // same index as off[31:2] from the full 32-bit modular difference.
      dec_word_off = dec_addr[31:2] - BASE_WORD;
      dec_in_range = (dec_addr >= BASE_ADDR)
                  && ({2'b00, dec_word_off} < DEPTH)
                  && (dec_addr[1:0] == 2'b00);
      dec_idx      = dec_word_off[AW-1:0];
   end

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of a combinational block is assigned a default first,
   // so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      load_rdata = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_valid) begin
               if (WAIT_INIT == 4'd0) begin
                  state_nxt  = S_RESP;
                  load_rdata = 1'b1;
               end else begin
                  state_nxt  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // The counter holds the wait cycles left, this one included.
            // The last wait cycle moves to RESP.
            if (wait_cnt == 4'd1) begin
               state_nxt  = S_RESP;
               load_rdata = 1'b1;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem_ready = (state == S_RESP);

   // --------------------------------------------------------------------------
   // Protocol check and write qualification
   // --------------------------------------------------------------------------
   logic in_flight;
   logic proto_bad;
   logic do_write;

   always_comb begin
      in_flight = (state == S_WAIT) || (state == S_RESP);
      proto_bad = in_flight && (!mem_valid
                             || (mem_addr  != lat_addr)
                             || (mem_wdata != lat_wdata)
                             || (mem_wstrb != lat_wstrb)
                             || (mem_instr != lat_instr));
      do_write  = (state == S_RESP) && dec_in_range && (lat_wstrb != 4'b0000);
   end

   // --------------------------------------------------------------------------
   // Request latch, response data, flags, counter
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. Every
   // register then samples the values from before the edge, whatever order
   // the blocks run in.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         lat_instr <= 1'b0;
         wait_cnt  <= '0;
         mem_rdata <= '0;
         err_oob   <= 1'b0;
         err_proto <= 1'b0;
         txn_count <= '0;
      end else begin
         if (state == S_IDLE && mem_valid) begin
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_wstrb <= mem_wstrb;
            lat_instr <= mem_instr;
            wait_cnt  <= WAIT_INIT;
         end else if (state == S_WAIT) begin
            wait_cnt  <= wait_cnt - 4'd1;
         end

         // The RAM is read here, one edge before any write at the edge
         // leaving RESP, so a write returns the word as it was before.
         if (load_rdata) begin
            if (dec_in_range) begin
               mem_rdata <= ram[dec_idx];
            end else begin
               mem_rdata <= '0;
               err_oob   <= 1'b1;
            end
         end

         if (proto_bad)
            err_proto <= 1'b1;

         if (state == S_RESP)
            txn_count <= txn_count + 32'd1;
      end
   end

   // --------------------------------------------------------------------------
   // RAM write port
   // --------------------------------------------------------------------------
   // NOTE: the RAM array has no reset. Clearing it would turn a block RAM
   // into a register file and cost MEM_WORDS cycles of reset sequencing. Only
   // the write enable respects reset.
   always_ff @(posedge clk) begin
      if (!reset && do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_wstrb[i])
               ram[dec_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_picorv32_mem_responder
//
// The bench instantiates two responders:
//   dut_m : WAIT_CYCLES=2, BASE_ADDR=0, MEM_WORDS=1024 (main vectors)
//   dut_z : WAIT_CYCLES=0, BASE_ADDR=0x100, MEM_WORDS=16 (back-to-back, window)
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_picorv32_mem_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // main responder
   logic        m_valid, m_instr;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ready, m_oob, m_proto;
   logic [31:0] m_rdata, m_count;

   // zero-wait responder
   logic        z_valid, z_instr;
   logic [31:0] z_addr, z_wdata;
   logic [3:0]  z_wstrb;
   logic        z_ready, z_oob, z_proto;
   logic [31:0] z_rdata, z_count;

   picorv32_mem_responder #(
      .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)
   ) dut_m (
      .clk(clk), .reset(reset),
      .mem_valid(m_valid), .mem_instr(m_instr), .mem_addr(m_addr),
      .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
      .mem_ready(m_ready), .mem_rdata(m_rdata),
      .err_oob(m_oob), .err_proto(m_proto), .txn_count(m_count)
   );

   picorv32_mem_responder #(
      .MEM_WORDS(16), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(0)
   ) dut_z (
      .clk(clk), .reset(reset),
      .mem_valid(z_valid), .mem_instr(z_instr), .mem_addr(z_addr),
      .mem_wdata(z_wdata), .mem_wstrb(z_wstrb),
      .mem_ready(z_ready), .mem_rdata(z_rdata),
      .err_oob(z_oob), .err_proto(z_proto), .txn_count(z_count)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        chk;        // compare rdata (first writes see unknown RAM)
      logic [31:0] exp_rdata;
      logic        exp_oob;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request on dut_m and holds it until mem_ready. It returns
   // one cycle after the response, with mem_valid low again.
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] rdata);
      int lat;
      bit seen;
      m_valid = 1'b1;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
      m_instr = (wstrb == 4'b0000);
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         tick();
         if (m_ready) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check("latency", 32'(lat), 32'd3);
      rdata = m_rdata;
      tick();
      m_valid = 1'b0;
      m_wstrb = 4'b0000;
      check("ready_single_cycle", {31'd0, m_ready}, 32'd0);
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;

      vecs[0]  = '{addr:32'h0000_0000, wdata:32'h0BAD_F00D, wstrb:4'hF, chk:1'b0, exp_rdata:32'h0,         exp_oob:1'b0};
      vecs[1]  = '{addr:32'h0000_0010, wdata:32'hDEAD_BEEF, wstrb:4'hF, chk:1'b0, exp_rdata:32'h0,         exp_oob:1'b0};
      vecs[2]  = '{addr:32'h0000_0010, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'hDEAD_BEEF, exp_oob:1'b0};
      vecs[3]  = '{addr:32'h0000_0010, wdata:32'h1122_3344, wstrb:4'hF, chk:1'b1, exp_rdata:32'hDEAD_BEEF, exp_oob:1'b0};
      vecs[4]  = '{addr:32'h0000_0010, wdata:32'hAABB_CCDD, wstrb:4'h5, chk:1'b1, exp_rdata:32'h1122_3344, exp_oob:1'b0};
      vecs[5]  = '{addr:32'h0000_0010, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h11BB_33DD, exp_oob:1'b0};
      vecs[6]  = '{addr:32'h0000_0020, wdata:32'hCAFE_F00D, wstrb:4'hF, chk:1'b0, exp_rdata:32'h0,         exp_oob:1'b0};
      vecs[7]  = '{addr:32'h0000_0FFC, wdata:32'h1234_5678, wstrb:4'hF, chk:1'b0, exp_rdata:32'h0,         exp_oob:1'b0};
      vecs[8]  = '{addr:32'h0000_0FFC, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h1234_5678, exp_oob:1'b0};
      vecs[9]  = '{addr:32'h0000_1002, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h0,         exp_oob:1'b1};
      vecs[10] = '{addr:32'h0000_1000, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h0,         exp_oob:1'b1};
      vecs[11] = '{addr:32'h0000_1000, wdata:32'hFFFF_FFFF, wstrb:4'hF, chk:1'b1, exp_rdata:32'h0,         exp_oob:1'b1};
      vecs[12] = '{addr:32'h0000_0012, wdata:32'hFFFF_FFFF, wstrb:4'hF, chk:1'b1, exp_rdata:32'h0,         exp_oob:1'b1};
      vecs[13] = '{addr:32'h0000_0000, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h0BAD_F00D, exp_oob:1'b1};
      vecs[14] = '{addr:32'h0000_0010, wdata:32'h0,         wstrb:4'h0, chk:1'b1, exp_rdata:32'h11BB_33DD, exp_oob:1'b1};

      reset   = 1'b1;
      m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      z_valid = 1'b0; z_instr = 1'b0; z_addr = '0; z_wdata = '0; z_wstrb = '0;
      tick();
      tick();

      // ---- reset state ----
      check("rst_ready", {31'd0, m_ready}, 32'd0);
      check("rst_rdata", m_rdata, 32'd0);
      check("rst_oob",   {31'd0, m_oob},   32'd0);
      check("rst_proto", {31'd0, m_proto}, 32'd0);
      check("rst_count", m_count, 32'd0);
      reset     = 1'b0;
      exp_count = 32'd0;
      tick();

      // ---- table-driven transactions on dut_m ----
      for (int i = 0; i < 15; i++) begin
         do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
         exp_count = exp_count + 32'd1;
         if (vecs[i].chk)
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_oob", i),   {31'd0, m_oob},   {31'd0, vecs[i].exp_oob});
         check($sformatf("vec%0d_proto", i), {31'd0, m_proto}, 32'd0);
         check($sformatf("vec%0d_count", i), m_count, exp_count);
      end

      // ---- address changes during WAIT ----
      m_valid = 1'b1; m_addr = 32'h20; m_wdata = '0; m_wstrb = 4'h0; m_instr = 1'b0;
      tick();                              // first WAIT cycle
      check("chg_proto_before", {31'd0, m_proto}, 32'd0);
      m_addr = 32'h24;
      tick();
      check("chg_proto_after", {31'd0, m_proto}, 32'd1);
      tick();
      check("chg_ready", {31'd0, m_ready}, 32'd1);
      check("chg_rdata", m_rdata, 32'hCAFE_F00D);
      tick();
      m_valid = 1'b0;
      exp_count = exp_count + 32'd1;
      check("chg_count", m_count, exp_count);

      // ---- reset clears sticky flags and counter ----
      reset = 1'b1;
      tick();
      check("rst2_oob",   {31'd0, m_oob},   32'd0);
      check("rst2_proto", {31'd0, m_proto}, 32'd0);
      check("rst2_count", m_count, 32'd0);
      check("rst2_rdata", m_rdata, 32'd0);
      reset = 1'b0;
      exp_count = 32'd0;
      tick();

      // ---- mem_valid dropped mid-WAIT ----
      m_valid = 1'b1; m_addr = 32'h10; m_wstrb = 4'h0;
      tick();
      m_valid = 1'b0;
      tick();
      check("drop_proto", {31'd0, m_proto}, 32'd1);
      tick();
      check("drop_ready", {31'd0, m_ready}, 32'd1);
      check("drop_rdata", m_rdata, 32'h11BB_33DD);
      tick();
      exp_count = exp_count + 32'd1;
      check("drop_count", m_count, exp_count);

      // ---- reset during WAIT of a write ----
      do_txn(32'h30, 32'h0102_0304, 4'hF, rd);
      m_valid = 1'b1; m_addr = 32'h30; m_wdata = 32'hFFFF_FFFF; m_wstrb = 4'hF; m_instr = 1'b0;
      tick();                              // first WAIT cycle
      reset = 1'b1; m_valid = 1'b0; m_wstrb = 4'h0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rstwait_no_ready", {31'd0, m_ready}, 32'd0);
         tick();
      end
      check("rstwait_oob",   {31'd0, m_oob},   32'd0);
      check("rstwait_proto", {31'd0, m_proto}, 32'd0);
      check("rstwait_count", m_count, 32'd0);
      do_txn(32'h30, 32'h0, 4'h0, rd);
      check("rstwait_word", rd, 32'h0102_0304);
      check("rstwait_count1", m_count, 32'd1);

      // ---- zero-wait back-to-back on dut_z ----
      z_valid = 1'b1; z_addr = 32'h104; z_wdata = 32'hA5A5_A5A5; z_wstrb = 4'hF;
      tick();
      check("b2b_ready1", {31'd0, z_ready}, 32'd1);
      tick();                              // IDLE: switch to a read of the same word
      check("b2b_idle1", {31'd0, z_ready}, 32'd0);
      z_wstrb = 4'h0;
      tick();
      check("b2b_ready2", {31'd0, z_ready}, 32'd1);
      check("b2b_rdata",  z_rdata, 32'hA5A5_A5A5);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("b2b_pattern%0d", k), {31'd0, z_ready}, {31'd0, (k % 2) == 1});
      end
      tick();                              // IDLE: release the bus
      z_valid = 1'b0;
      check("b2b_proto", {31'd0, z_proto}, 32'd0);
      check("b2b_count", z_count, 32'd4);

      // ---- window edges on dut_z ----
      z_valid = 1'b1; z_addr = 32'h13C;    // last in-range word
      tick();
      check("win_top_ready", {31'd0, z_ready}, 32'd1);
      check("win_top_oob",   {31'd0, z_oob},   32'd0);
      tick();
      z_addr = 32'hFC;                     // just below BASE_ADDR
      tick();
      check("win_low_rdata", z_rdata, 32'd0);
      check("win_low_oob",   {31'd0, z_oob}, 32'd1);
      tick();
      z_addr = 32'h140;                    // one past the end
      tick();
      check("win_high_rdata", z_rdata, 32'd0);
      tick();
      z_valid = 1'b0;
      check("win_proto", {31'd0, z_proto}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
